// File: rtl/csr_mtrap_unit.sv
// csr_mtrap_unit: machine-mode CSR file and trap/redirect controller for the CU.
// Define CSR_COUNTER_EN to build the 64-bit mcycle/minstret counters.
module csr_mtrap_unit #(
    parameter int unsigned            XLEN      = 32,
    parameter int unsigned            NUM_IRQ   = 4,
    parameter logic [XLEN-1:0]        MTVEC_RST = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [11:0]         csr_read_index,
    input  logic [11:0]         csr_write_index,
    input  logic                csr_write,
    input  logic [XLEN-1:0]     csr_data_w,
    output logic [XLEN-1:0]     csr_data_r,
    output logic                illegal_csr,
    input  logic                exc_valid,
    input  logic [3:0]          exc_cause,
    input  logic [XLEN-1:0]     exc_pc,
    input  logic [XLEN-1:0]     exc_tval,
    input  logic                int_acc,
    input  logic [XLEN-1:0]     int_pc,
    input  logic                m_ret,
    input  logic                irq_soft,
    input  logic                irq_timer,
    input  logic [NUM_IRQ-1:0]  irq_ext,
    input  logic                inst_retire,
    output logic                int_req,
    output logic                trap_taken,
    output logic [XLEN-1:0]     trap_pc
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
`ifdef CSR_COUNTER_EN
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
`endif

    localparam logic [XLEN-1:0] MIE_MASK =
        (((XLEN'(1) << NUM_IRQ) - XLEN'(1)) << 16) | XLEN'(32'h88);
    localparam logic [XLEN-1:0] EPC_MASK = ~XLEN'(3);

    logic            mstatus_mie, mstatus_mpie;
    logic [XLEN-1:0] mie_q, mip_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
    logic [XLEN-1:0] mstatus_rd, irq_vec, pending, trap_base, int_target;
    logic [4:0]      irq_cause;
    logic            take_exc, take_int, take_ret, do_write;

    function automatic logic is_mapped(input logic [11:0] idx);
        case (idx)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH,
            A_MEPC, A_MCAUSE, A_MTVAL, A_MIP:          is_mapped = 1'b1;
`ifdef CSR_COUNTER_EN
            A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH: is_mapped = 1'b1;
`endif
            default:                                   is_mapped = 1'b0;
        endcase
    endfunction

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mstatus_mpie;
        mstatus_rd[3]     = mstatus_mie;
        irq_vec                   = '0;
        irq_vec[3]                = irq_soft;
        irq_vec[7]                = irq_timer;
        irq_vec[16 +: NUM_IRQ]    = irq_ext;
    end

    assign pending = mip_q & mie_q;

    // Sources are tested lowest priority first so the last hit wins.
    always_comb begin
        irq_cause = 5'd0;
        if (pending[7])  irq_cause = 5'd7;
        if (pending[3])  irq_cause = 5'd3;
        if (pending[11]) irq_cause = 5'd11;
        for (int unsigned i = 0; i < NUM_IRQ; i++)
            if (pending[16 + i]) irq_cause = 5'(16 + i);
    end

    assign trap_base  = {mtvec_q[XLEN-1:2], 2'b00};
    assign int_target = (mtvec_q[1:0] == 2'b01) ? trap_base + XLEN'({irq_cause, 2'b00})
                                                : trap_base;

    assign take_exc = exc_valid;
    assign take_int = !exc_valid && int_acc && int_req;
    assign take_ret = !exc_valid && !take_int && m_ret;
    assign do_write = csr_write && !exc_valid && !take_int && !m_ret
                      && is_mapped(csr_write_index);

    assign illegal_csr = !is_mapped(csr_read_index)
                         || (csr_write && !is_mapped(csr_write_index));

`ifdef CSR_COUNTER_EN
    logic [63:0] mcycle_q, minstret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (do_write && csr_write_index == A_MCYCLE)
                mcycle_q <= {mcycle_q[63:32], csr_data_w};
            else if (do_write && csr_write_index == A_MCYCLEH)
                mcycle_q <= {csr_data_w, mcycle_q[31:0]};
            else
                mcycle_q <= mcycle_q + 64'd1;
            if (do_write && csr_write_index == A_MINSTRET)
                minstret_q <= {minstret_q[63:32], csr_data_w};
            else if (do_write && csr_write_index == A_MINSTRETH)
                minstret_q <= {csr_data_w, minstret_q[31:0]};
            else if (inst_retire)
                minstret_q <= minstret_q + 64'd1;
        end
    end
`else
    logic unused_retire;
    assign unused_retire = inst_retire;
`endif

    always_comb begin
        csr_data_r = '0;
        case (csr_read_index)
            A_MSTATUS:   csr_data_r = mstatus_rd;
            A_MIE:       csr_data_r = mie_q;
            A_MTVEC:     csr_data_r = mtvec_q;
            A_MSCRATCH:  csr_data_r = mscratch_q;
            A_MEPC:      csr_data_r = mepc_q;
            A_MCAUSE:    csr_data_r = mcause_q;
            A_MTVAL:     csr_data_r = mtval_q;
            A_MIP:       csr_data_r = mip_q;
`ifdef CSR_COUNTER_EN
            A_MCYCLE:    csr_data_r = mcycle_q[31:0];
            A_MCYCLEH:   csr_data_r = mcycle_q[63:32];
            A_MINSTRET:  csr_data_r = minstret_q[31:0];
            A_MINSTRETH: csr_data_r = minstret_q[63:32];
`endif
            default:     csr_data_r = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mie_q        <= '0;
            mip_q        <= '0;
            mtvec_q      <= MTVEC_RST;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
            int_req      <= 1'b0;
            trap_taken   <= 1'b0;
            trap_pc      <= '0;
        end else begin
            mip_q      <= irq_vec;
            int_req    <= mstatus_mie && (pending != '0);
            trap_taken <= 1'b0;
            if (take_exc) begin
                mepc_q       <= exc_pc & EPC_MASK;
                mcause_q     <= {{(XLEN-4){1'b0}}, exc_cause};
                mtval_q      <= exc_tval;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
                trap_taken   <= 1'b1;
                trap_pc      <= trap_base;
            end else if (take_int) begin
                mepc_q       <= int_pc & EPC_MASK;
                mcause_q     <= {1'b1, {(XLEN-6){1'b0}}, irq_cause};
                mtval_q      <= '0;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
                trap_taken   <= 1'b1;
                trap_pc      <= int_target;
            end else if (take_ret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
                trap_taken   <= 1'b1;
                trap_pc      <= mepc_q;
            end else if (do_write) begin
                case (csr_write_index)
                    A_MSTATUS: begin
                        mstatus_mie  <= csr_data_w[3];
                        mstatus_mpie <= csr_data_w[7];
                    end
                    A_MIE:      mie_q      <= csr_data_w & MIE_MASK;
                    A_MTVEC:    mtvec_q    <= csr_data_w;
                    A_MSCRATCH: mscratch_q <= csr_data_w;
                    A_MEPC:     mepc_q     <= csr_data_w & EPC_MASK;
                    A_MCAUSE:   mcause_q   <= csr_data_w;
                    A_MTVAL:    mtval_q    <= csr_data_w;
                    default:    ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_csr_mtrap_unit.sv
// Bench for csr_mtrap_unit: directed vector table and trap sequences, then
// randomized traffic checked against an address-keyed CSR model.
module tb_csr_mtrap_unit;

    localparam int          NIRQ       = 4;
    localparam logic [31:0] MTVEC_INIT = 32'h0000_0200;

    logic            clk, rst;
    logic [11:0]     csr_read_index, csr_write_index;
    logic            csr_write;
    logic [31:0]     csr_data_w, csr_data_r;
    logic            illegal_csr;
    logic            exc_valid;
    logic [3:0]      exc_cause;
    logic [31:0]     exc_pc, exc_tval;
    logic            int_acc;
    logic [31:0]     int_pc;
    logic            m_ret, irq_soft, irq_timer;
    logic [NIRQ-1:0] irq_ext;
    logic            inst_retire;
    logic            int_req, trap_taken;
    logic [31:0]     trap_pc;

    csr_mtrap_unit #(.XLEN(32), .NUM_IRQ(NIRQ), .MTVEC_RST(MTVEC_INIT)) dut (
        .clk(clk), .rst(rst),
        .csr_read_index(csr_read_index), .csr_write_index(csr_write_index),
        .csr_write(csr_write), .csr_data_w(csr_data_w), .csr_data_r(csr_data_r),
        .illegal_csr(illegal_csr),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .int_acc(int_acc), .int_pc(int_pc), .m_ret(m_ret),
        .irq_soft(irq_soft), .irq_timer(irq_timer), .irq_ext(irq_ext),
        .inst_retire(inst_retire),
        .int_req(int_req), .trap_taken(trap_taken), .trap_pc(trap_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int applied = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        csr_write = 1'b0; exc_valid = 1'b0; int_acc = 1'b0; m_ret = 1'b0;
        inst_retire = 1'b0; csr_write_index = 12'h340; csr_data_w = '0;
        exc_cause = '0; exc_pc = '0; exc_tval = '0; int_pc = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] idx, input logic [31:0] d);
        csr_write = 1'b1; csr_write_index = idx; csr_data_w = d;
        tick();
        csr_write = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] idx, input logic [31:0] exp);
        csr_read_index = idx;
        #1;
        check(name, csr_data_r, exp);
    endtask

    typedef struct {
        logic [11:0] widx;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        ill;
    } vec_t;
    vec_t tbl[11];

    // Reference model: CSRs kept by address, with a per-address writable-bit mask.
    bit [31:0] m_csr [int];
    bit [31:0] m_wmask [int];
    bit        m_int_req, m_tt;
    bit [31:0] m_tpc;

    function automatic void model_init();
        m_csr.delete();
        m_wmask.delete();
        m_csr['h300] = 32'h1800;     m_wmask['h300] = 32'h88;
        m_csr['h304] = 0;            m_wmask['h304] = (((32'h1 << NIRQ) - 1) << 16) | 32'h88;
        m_csr['h305] = MTVEC_INIT;   m_wmask['h305] = 32'hFFFF_FFFF;
        m_csr['h340] = 0;            m_wmask['h340] = 32'hFFFF_FFFF;
        m_csr['h341] = 0;            m_wmask['h341] = 32'hFFFF_FFFC;
        m_csr['h342] = 0;            m_wmask['h342] = 32'hFFFF_FFFF;
        m_csr['h343] = 0;            m_wmask['h343] = 32'hFFFF_FFFF;
        m_csr['h344] = 0;            m_wmask['h344] = 32'h0;
        m_int_req = 1'b0; m_tt = 1'b0; m_tpc = '0;
    endfunction

    function automatic void model_edge();
        bit [31:0] pend, ms, mipv, base;
        int prio[$];
        int cause, w;
        pend = m_csr['h344] & m_csr['h304];
        ms   = m_csr['h300];
        base = m_csr['h305] & ~32'h3;
        mipv = '0;
        mipv[3] = irq_soft;
        mipv[7] = irq_timer;
        for (int i = 0; i < NIRQ; i++) mipv[16 + i] = irq_ext[i];
        w = int'(csr_write_index);
        m_tt = 1'b0;
        if (exc_valid) begin
            m_csr['h341] = exc_pc & ~32'h3;
            m_csr['h342] = {28'h0, exc_cause};
            m_csr['h343] = exc_tval;
            m_csr['h300] = 32'h1800 | (ms[3] ? 32'h80 : 32'h0);
            m_tt = 1'b1; m_tpc = base;
        end else if (int_acc && m_int_req) begin
            for (int i = NIRQ - 1; i >= 0; i--) prio.push_back(16 + i);
            prio.push_back(11); prio.push_back(3); prio.push_back(7);
            cause = 0;
            for (int k = 0; k < prio.size(); k++)
                if (pend[prio[k]]) begin cause = prio[k]; break; end
            m_csr['h342] = 32'h8000_0000 | 32'(cause);
            m_csr['h341] = int_pc & ~32'h3;
            m_csr['h343] = 0;
            m_csr['h300] = 32'h1800 | (ms[3] ? 32'h80 : 32'h0);
            m_tt = 1'b1;
            m_tpc = base + (((m_csr['h305] & 32'h3) == 1) ? 32'(4 * cause) : 32'h0);
        end else if (m_ret) begin
            m_csr['h300] = 32'h1880 | (ms[7] ? 32'h8 : 32'h0);
            m_tt = 1'b1; m_tpc = m_csr['h341];
        end else if (csr_write && m_csr.exists(w)) begin
            m_csr[w] = (m_csr[w] & ~m_wmask[w]) | (csr_data_w & m_wmask[w]);
        end
        m_int_req = ms[3] && (pend != 0);
        m_csr['h344] = mipv;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int addrs[10];
        int r, w;
        bit [31:0] pend_now, exp_d;
        bit        exp_i;

        tbl[0]  = '{12'h305, 32'h0000_0100, 32'h0000_0100, 1'b0};
        tbl[1]  = '{12'h300, 32'hFFFF_FFFF, 32'h0000_1888, 1'b0};
        tbl[2]  = '{12'h300, 32'h0000_0000, 32'h0000_1800, 1'b0};
        tbl[3]  = '{12'h304, 32'hFFFF_FFFF, 32'h000F_0088, 1'b0};
        tbl[4]  = '{12'h341, 32'h1234_5677, 32'h1234_5674, 1'b0};
        tbl[5]  = '{12'h340, 32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0};
        tbl[6]  = '{12'h342, 32'h8000_000B, 32'h8000_000B, 1'b0};
        tbl[7]  = '{12'h343, 32'h0000_DEAD, 32'h0000_DEAD, 1'b0};
        tbl[8]  = '{12'h344, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        tbl[9]  = '{12'h7C0, 32'h0000_0055, 32'h0000_0000, 1'b1};
        tbl[10] = '{12'h304, 32'h0000_0000, 32'h0000_0000, 1'b0};
        addrs = '{'h300, 'h304, 'h305, 'h340, 'h341, 'h342, 'h343, 'h344, 'h7C0, 'hF11};

        rst = 1'b0; idle();
        irq_soft = 1'b0; irq_timer = 1'b0; irq_ext = '0; csr_read_index = 12'h300;
        #12 rst = 1'b1;
        tick();

        rd_chk("reset_mstatus", 12'h300, 32'h1800);
        rd_chk("reset_mtvec", 12'h305, MTVEC_INIT);
        check("reset_int_req", 32'(int_req), 32'h0);
        check("reset_trap_taken", 32'(trap_taken), 32'h0);
        check("reset_trap_pc", trap_pc, 32'h0);

        for (int i = 0; i < 11; i++) begin
            wr(tbl[i].widx, tbl[i].wdata);
            rd_chk($sformatf("tbl%0d_data", i), tbl[i].widx, tbl[i].rdata);
            check($sformatf("tbl%0d_illegal", i), 32'(illegal_csr), 32'(tbl[i].ill));
        end
        csr_write = 1'b1; csr_write_index = 12'h7C0; csr_read_index = 12'h305;
        #1 check("illegal_on_write", 32'(illegal_csr), 32'h1);
        csr_write = 1'b0;

        // Exception entry
        wr(12'h305, 32'h100);
        wr(12'h300, 32'h8);
        exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h40; exc_tval = 32'hDEAD;
        tick();
        idle();
        check("exc_trap_taken", 32'(trap_taken), 32'h1);
        check("exc_trap_pc", trap_pc, 32'h100);
        rd_chk("exc_mepc", 12'h341, 32'h40);
        rd_chk("exc_mcause", 12'h342, 32'h2);
        rd_chk("exc_mtval", 12'h343, 32'hDEAD);
        rd_chk("exc_mstatus", 12'h300, 32'h1880);
        tick();
        check("exc_pulse_end", 32'(trap_taken), 32'h0);

        // Vectored timer interrupt, then mret
        irq_timer = 1'b1;
        wr(12'h305, 32'h101);
        wr(12'h304, 32'h80);
        wr(12'h300, 32'h8);
        tick();
        check("irq_int_req", 32'(int_req), 32'h1);
        int_acc = 1'b1; int_pc = 32'h88;
        tick();
        idle(); irq_timer = 1'b0;
        check("irq_trap_taken", 32'(trap_taken), 32'h1);
        check("irq_trap_pc", trap_pc, 32'h11C);
        rd_chk("irq_mcause", 12'h342, 32'h8000_0007);
        rd_chk("irq_mepc", 12'h341, 32'h88);
        rd_chk("irq_mtval", 12'h343, 32'h0);
        rd_chk("irq_mstatus", 12'h300, 32'h1880);
        m_ret = 1'b1;
        tick();
        idle();
        check("mret_trap_taken", 32'(trap_taken), 32'h1);
        check("mret_trap_pc", trap_pc, 32'h88);
        rd_chk("mret_mstatus", 12'h300, 32'h1888);
        int_acc = 1'b1;
        tick();
        idle();
        check("int_acc_ignored", 32'(trap_taken), 32'h0);

        // Same-edge exception, mret and CSR write
        wr(12'h340, 32'h1111);
        exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h200;
        m_ret = 1'b1; csr_write = 1'b1; csr_write_index = 12'h340; csr_data_w = 32'h2222;
        rd_chk("rw_same_cycle_old", 12'h340, 32'h1111);
        tick();
        idle();
        check("prio_trap_taken", 32'(trap_taken), 32'h1);
        check("prio_trap_pc", trap_pc, 32'h100);
        rd_chk("prio_mscratch", 12'h340, 32'h1111);
        rd_chk("prio_mstatus", 12'h300, 32'h1880);
        rd_chk("prio_mcause", 12'h342, 32'h5);

        // Asynchronous reset while the redirect pulse is high
        exc_valid = 1'b1;
        tick();
        idle();
        check("mid_trap_taken", 32'(trap_taken), 32'h1);
        #2 rst = 1'b0;
        #1 check("async_rst_trap_taken", 32'(trap_taken), 32'h0);
        check("async_rst_trap_pc", trap_pc, 32'h0);
        rd_chk("async_rst_mtvec", 12'h305, MTVEC_INIT);
        rd_chk("async_rst_mstatus", 12'h300, 32'h1800);
        rst = 1'b1;
        tick();

`ifdef CSR_COUNTER_EN
        wr(12'hB00, 32'hFFFF_FFFF);
        tick();
        tick();
        rd_chk("mcycleh_carry", 12'hB80, 32'h1);
        rd_chk("mcycle_wrap", 12'hB00, 32'h1);
        wr(12'hB02, 32'h5);
        inst_retire = 1'b1;
        tick();
        tick();
        inst_retire = 1'b0;
        rd_chk("minstret_count", 12'hB02, 32'h7);
`else
        rd_chk("no_counter_data", 12'hB00, 32'h0);
        check("no_counter_illegal", 32'(illegal_csr), 32'h1);
`endif

        // Randomized traffic against the model
        rst = 1'b0;
        #2 rst = 1'b1;
        model_init();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            r = addrs[$urandom_range(0, 9)];
            w = addrs[$urandom_range(0, 9)];
            csr_read_index  = 12'(r);
            csr_write_index = 12'(w);
            csr_write  = ($urandom_range(0, 2) == 0);
            csr_data_w = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                irq_soft = 1'($urandom); irq_timer = 1'($urandom); irq_ext = NIRQ'($urandom);
            end
            exc_valid = ($urandom_range(0, 31) == 0);
            exc_cause = 4'($urandom); exc_pc = $urandom; exc_tval = $urandom;
            pend_now  = m_csr['h344] & m_csr['h304];
            int_acc   = ($urandom_range(0, 1) == 1) && (!m_int_req || pend_now != 0);
            int_pc    = $urandom;
            m_ret     = ($urandom_range(0, 11) == 0);
            inst_retire = 1'($urandom);
            #1;
            exp_d = m_csr.exists(r) ? m_csr[r] : 32'h0;
            exp_i = !m_csr.exists(r) || (csr_write && !m_csr.exists(w));
            check("rnd_data_r", csr_data_r, exp_d);
            check("rnd_illegal", 32'(illegal_csr), 32'(exp_i));
            check("rnd_int_req", 32'(int_req), 32'(m_int_req));
            check("rnd_trap_taken", 32'(trap_taken), 32'(m_tt));
            if (m_tt) check("rnd_trap_pc", trap_pc, m_tpc);
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
